// File: rtl/systolic_pkg.sv
// Shared types and sizes for the systolic array job sequencer.
package systolic_pkg;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int KW  = 8;
  localparam int CW  = 2 * DW + 1;
  localparam int DCW = $clog2(2 * N);

  // The drain counter runs DRAIN_LAST..0, one cycle per step.
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(2 * N - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_e;

  function automatic logic [DW-1:0] lane(input logic [N*DW-1:0] bus, input int idx);
    return bus[idx*DW +: DW];
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth operand delay line with synchronous clear; one per skewed edge lane.
module skew_delay_line #(
  parameter int DW    = 16,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          clr_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o
);

  logic [DW-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every stage samples its neighbour's old value.
    // NOTE: the stages are cleared explicitly; a stale operand would be accumulated as a real product.
    if (clr_i) begin
      for (int s = 0; s < DEPTH; s++) stage_q[s] <= '0;
    end else begin
      stage_q[0] <= din_i;
      for (int s = 1; s < DEPTH; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_array_ctrl.sv
// Job sequencer for an NxN output-stationary systolic array: reads operands,
// skews them onto the west/north edges and drives the shared PE enable/clear.
module systolic_array_ctrl
  import systolic_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [KW-1:0]   rd_k,
  input  logic [N*DW-1:0] a_col,
  input  logic [N*DW-1:0] b_row,
  output logic [N*DW-1:0] a_feed,
  output logic [N*DW-1:0] b_feed,
  output logic            arr_en,
  output logic            arr_rst
);

  state_e         state_q, state_d;
  logic [KW-1:0]  klen_q, klen_d;
  logic [KW-1:0]  k_q, k_d;
  logic [DCW-1:0] drain_q, drain_d;
  logic           vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      klen_q  <= '0;
      k_q     <= '0;
      drain_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      klen_q  <= klen_d;
      k_q     <= k_d;
      drain_q <= drain_d;
      vld_q   <= rd_en;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    state_d = state_q;
    klen_d  = klen_q;
    k_d     = k_q;
    drain_d = drain_q;
    busy    = 1'b1;
    done    = 1'b0;
    rd_en   = 1'b0;
    arr_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          klen_d  = k_len;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        k_d     = '0;
        drain_d = DRAIN_LAST;
        state_d = (klen_q != '0) ? FEED : DONE;
      end
      FEED: begin
        // The first read's data only reaches PE[0][0] one cycle later.
        rd_en  = 1'b1;
        arr_en = (k_q != '0);
        k_d    = k_q + KW'(1);
        if (k_q == klen_q - KW'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        arr_en  = 1'b1;
        drain_d = drain_q - DCW'(1);
        if (drain_q == '0) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_k    = (state_q == FEED) ? k_q : '0;
  assign arr_rst = rst | (state_q == CLEAR);

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] a_gated, b_gated;

    // Idle-cycle buffer contents must never reach the array as operands.
    assign a_gated = vld_q ? lane(a_col, i) : '0;
    assign b_gated = vld_q ? lane(b_row, i) : '0;

    if (i == 0) begin : g_pass
      assign a_feed[DW-1:0] = a_gated;
      assign b_feed[DW-1:0] = b_gated;
    end else begin : g_skew
      skew_delay_line #(.DW(DW), .DEPTH(i)) u_a_skew (
        .clk    (clk),
        .clr_i  (arr_rst),
        .din_i  (a_gated),
        .dout_o (a_feed[i*DW +: DW])
      );
      skew_delay_line #(.DW(DW), .DEPTH(i)) u_b_skew (
        .clk    (clk),
        .clr_i  (arr_rst),
        .din_i  (b_gated),
        .dout_o (b_feed[i*DW +: DW])
      );
    end
  end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl with behavioural operand buffers and a 4x4 PE
// array; results are compared against a plain matrix-multiply reference.
module tb_systolic_array_ctrl;
  import systolic_pkg::*;

  localparam int KMAX = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            busy, done, rd_en, arr_en, arr_rst;
  logic [KW-1:0]   rd_k;
  logic [N*DW-1:0] a_col, b_row, a_feed, b_feed;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mat_a  [N][KMAX];
  logic [DW-1:0] mat_b  [KMAX][N];
  logic [DW-1:0] pe_a   [N][N];
  logic [DW-1:0] pe_b   [N][N];
  logic [CW-1:0] pe_acc [N][N];
  logic [CW-1:0] pe_c   [N][N];

  always #5 clk = ~clk;

  systolic_array_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .k_len   (k_len),
    .busy    (busy),
    .done    (done),
    .rd_en   (rd_en),
    .rd_k    (rd_k),
    .a_col   (a_col),
    .b_row   (b_row),
    .a_feed  (a_feed),
    .b_feed  (b_feed),
    .arr_en  (arr_en),
    .arr_rst (arr_rst)
  );

  // Operand buffers: one-cycle read latency, random junk when not read.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rd_en && rd_k < KW'(KMAX)) begin
        a_col[i*DW +: DW] <= mat_a[i][rd_k[2:0]];
        b_row[i*DW +: DW] <= mat_b[rd_k[2:0]][i];
      end else begin
        a_col[i*DW +: DW] <= DW'($urandom);
        b_row[i*DW +: DW] <= DW'($urandom);
      end
    end
  end

  function automatic logic [DW-1:0] pe_west(int i, int j);
    if (j == 0) return a_feed[i*DW +: DW];
    return pe_a[i][j-1];
  endfunction

  function automatic logic [DW-1:0] pe_north(int i, int j);
    if (i == 0) return b_feed[j*DW +: DW];
    return pe_b[i-1][j];
  endfunction

  // Output-stationary PE grid: operands hop east/south, C_out takes the prior sum.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (arr_rst) begin
          pe_a[i][j]   <= '0;
          pe_b[i][j]   <= '0;
          pe_acc[i][j] <= '0;
          pe_c[i][j]   <= '0;
        end else if (arr_en) begin
          pe_a[i][j]   <= pe_west(i, j);
          pe_b[i][j]   <= pe_north(i, j);
          pe_acc[i][j] <= pe_acc[i][j] + CW'(pe_west(i, j)) * CW'(pe_north(i, j));
          pe_c[i][j]   <= pe_acc[i][j];
        end
      end
    end
  end

  function automatic logic [CW-1:0] ref_c(int i, int j, int kl);
    longint unsigned sum = 0;
    for (int k = 0; k < kl; k++) sum += 64'(mat_a[i][k]) * 64'(mat_b[k][j]);
    return CW'(sum);
  endfunction

  // Operand k of lane l is on the edge at cycle k+2+l, zero otherwise.
  function automatic logic [N*DW-1:0] ref_feed(bit is_a, int cyc, int kl);
    logic [N*DW-1:0] v = '0;
    for (int l = 0; l < N; l++) begin
      int k = cyc - 2 - l;
      if (k >= 0 && k < kl) v[l*DW +: DW] = is_a ? mat_a[l][k] : mat_b[k][l];
    end
    return v;
  endfunction

  task automatic fill_const(input logic [DW-1:0] a_val, input logic [DW-1:0] b_val);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KMAX; k++) begin
        mat_a[i][k] = a_val;
        mat_b[k][i] = b_val;
      end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KMAX; k++) begin
        mat_a[i][k] = DW'($urandom);
        mat_b[k][i] = DW'($urandom);
      end
  endtask

  // One job from IDLE through the done cycle; start re-pulsed at stray_cyc must be ignored.
  task automatic run_job(input int kl, input int stray_cyc);
    int              done_cyc;
    bit              rd, en;
    logic [KW+4:0]   got_ctrl, exp_ctrl;
    logic [N*DW-1:0] exp_a, exp_b;
    logic [CW-1:0]   exp_c;
    done_cyc = (kl == 0) ? 1 : kl + 2 * N + 1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_before_start k=%0d: busy=%b done=%b, expected 0 0", kl, busy, done);
    end
    start = 1'b1;
    k_len = KW'(kl);
    for (int cyc = 0; cyc <= done_cyc; cyc++) begin
      @(negedge clk);
      start    = (cyc == stray_cyc);
      rd       = (kl > 0) && (cyc >= 1) && (cyc <= kl);
      en       = (kl > 0) && (cyc >= 2) && (cyc <= kl + 2 * N);
      exp_ctrl = {1'b1, cyc == done_cyc, rd, rd ? KW'(cyc - 1) : KW'(0), en, cyc == 0};
      got_ctrl = {busy, done, rd_en, rd_k, arr_en, arr_rst};
      checks++;
      if (got_ctrl !== exp_ctrl) begin
        errors++;
        $display("FAIL ctrl k=%0d cyc=%0d: {busy,done,rd_en,rd_k,arr_en,arr_rst} got %b, expected %b",
                 kl, cyc, got_ctrl, exp_ctrl);
      end
      exp_a = ref_feed(1'b1, cyc, kl);
      exp_b = ref_feed(1'b0, cyc, kl);
      checks++;
      if (a_feed !== exp_a) begin
        errors++;
        $display("FAIL a_feed k=%0d cyc=%0d: got %h, expected %h", kl, cyc, a_feed, exp_a);
      end
      checks++;
      if (b_feed !== exp_b) begin
        errors++;
        $display("FAIL b_feed k=%0d cyc=%0d: got %h, expected %h", kl, cyc, b_feed, exp_b);
      end
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        exp_c = ref_c(i, j, kl);
        checks++;
        if (pe_c[i][j] !== exp_c) begin
          errors++;
          $display("FAIL c_out[%0d][%0d] k=%0d: got %h, expected %h", i, j, kl, pe_c[i][j], exp_c);
        end
      end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    k_len = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, rd_en, rd_k, arr_en, arr_rst} !== {3'b000, KW'(0), 2'b01}) begin
      errors++;
      $display("FAIL reset_ctrl: got busy=%b done=%b rd_en=%b rd_k=%0d arr_en=%b arr_rst=%b, expected 0 0 0 0 0 1",
               busy, done, rd_en, rd_k, arr_en, arr_rst);
    end
    checks++;
    if (a_feed !== '0 || b_feed !== '0) begin
      errors++;
      $display("FAIL reset_feeds: got a=%h b=%h, expected 0 0", a_feed, b_feed);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (arr_rst !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got arr_rst=%b busy=%b, expected 0 0", arr_rst, busy);
    end
  endtask

  task automatic test_identity();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KMAX; k++) begin
        mat_a[i][k] = (i == k) ? DW'(1) : DW'(0);
        mat_b[k][i] = DW'(k * N + i + 1);
      end
    run_job(4, -1);
  endtask

  task automatic test_wrap();
    fill_const(16'hFFFF, 16'hFFFF);
    run_job(4, -1);
  endtask

  task automatic test_zero_k();
    fill_random();
    run_job(0, -1);
  endtask

  task automatic test_back_to_back();
    fill_const(DW'(1), DW'(1));
    run_job(4, 5);
    fill_const(DW'(2), DW'(2));
    run_job(4, -1);
  endtask

  task automatic test_reset_mid_job();
    bit nz, saw;
    fill_random();
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(4);
    for (int cyc = 0; cyc <= 3; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (arr_rst !== 1'b1) begin
      errors++;
      $display("FAIL abort_arr_rst: got %b, expected 1", arr_rst);
    end
    @(negedge clk);
    checks++;
    if ({busy, done, rd_en, arr_en} !== 4'b0000 || a_feed !== '0 || b_feed !== '0) begin
      errors++;
      $display("FAIL abort_state: got busy=%b done=%b rd_en=%b arr_en=%b a=%h b=%h, expected all 0",
               busy, done, rd_en, arr_en, a_feed, b_feed);
    end
    nz = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (pe_c[i][j] !== '0) nz = 1'b1;
    checks++;
    if (nz) begin
      errors++;
      $display("FAIL abort_c_out: got a nonzero C_out, expected all 0");
    end
    rst = 1'b0;
    saw = 1'b0;
    repeat (KMAX + 2 * N + 4) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw = 1'b1;
    end
    checks++;
    if (saw) begin
      errors++;
      $display("FAIL abort_no_done: got done/busy activity after abort, expected none");
    end
  endtask

  task automatic test_single_k();
    for (int i = 0; i < N; i++) begin
      mat_a[i][0] = DW'(16'h1100 + i + 1);
      mat_b[0][i] = DW'(16'h2200 + i + 1);
    end
    run_job(1, -1);
  endtask

  task automatic test_random();
    int kl;
    for (int n = 0; n < 6; n++) begin
      fill_random();
      kl = int'($urandom_range(1, KMAX));
      run_job(kl, int'($urandom_range(0, kl + 2 * N)));
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    k_len = '0;
    test_reset();
    test_identity();
    test_wrap();
    test_zero_k();
    test_back_to_back();
    test_reset_mid_job();
    test_single_k();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
